// File: rtl/instruction_loader.sv
// Byte-stream program loader: assembles received bytes MSB-first into instruction
// words and writes them to instruction memory until the halt word is stored.
module instruction_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_ready,
  output logic               o_wr_en,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_DATA-1:0] o_wr_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [NB_ADDR:0]   o_word_count
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECEIVE,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             r_state;
  logic [NB_BCNT-1:0] r_byte_cnt;
  logic [NB_DATA-1:0] r_word;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_ADDR-1:0] r_wr_addr;
  logic [NB_DATA-1:0] r_wr_data;
  logic [NB_ADDR:0]   r_word_count;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic [NB_DATA-1:0] w_word_next;
  logic               w_last_byte;
  logic               w_is_halt;
  logic               w_mem_full;

  assign w_word_next = {r_word[NB_DATA-NB_BYTE-1:0], i_rx_data};
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_is_halt   = (r_word == HALT_WORD);
  assign w_mem_full  = (r_addr == LAST_ADDR);

  // NOTE: every register below uses non-blocking assignment so all state advances
  // together on the edge; blocking here would let later statements see new values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_addr       <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state      <= S_RECEIVE;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end
        end

        S_RECEIVE: begin
          if (i_rx_valid) begin
            r_word <= w_word_next;
            if (w_last_byte) begin
              // Capture the write port here so it is stable for the whole WRITE cycle.
              r_byte_cnt <= '0;
              r_wr_addr  <= r_addr;
              r_wr_data  <= w_word_next;
              r_state    <= S_WRITE;
            end else begin
              r_byte_cnt <= r_byte_cnt + NB_BCNT'(1);
            end
          end
        end

        S_WRITE: begin
          r_word_count <= r_word_count + 1'b1;
          if (w_is_halt) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_mem_full) begin
            r_state <= S_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_RECEIVE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The two strobes are gated by i_enable directly so a stall silences them at once.
  assign o_ready      = (r_state == S_RECEIVE) && i_enable;
  assign o_wr_en      = (r_state == S_WRITE) && i_enable;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_word_count;

  a_done_error_exclusive : assert property (
    @(posedge i_clock) disable iff (!i_reset) !(o_done && o_error));
  a_wr_en_while_busy : assert property (
    @(posedge i_clock) disable iff (!i_reset) o_wr_en |-> o_busy);
  a_ready_wr_exclusive : assert property (
    @(posedge i_clock) disable iff (!i_reset) !(o_ready && o_wr_en));

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: a 256-word and a 4-word instance share one stimulus
// stream and are compared every cycle against a transaction-level loader model.
`timescale 1ns/1ps
module tb_instruction_loader;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b1;
  logic       start   = 1'b0;
  logic       valid   = 1'b0;
  logic [7:0] data    = 8'h00;

  always #5 clk = ~clk;

  logic        rdy0, we0, busy0, done0, err0;
  logic [7:0]  wa0;
  logic [31:0] wd0;
  logic [8:0]  cnt0;
  logic        rdy1, we1, busy1, done1, err1;
  logic [1:0]  wa1;
  logic [31:0] wd1;
  logic [2:0]  cnt1;

  instruction_loader #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(8), .HALT_WORD(32'hFFFF_FFFF)) dut0 (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_start(start),
    .i_rx_data(data), .i_rx_valid(valid), .o_ready(rdy0), .o_wr_en(we0),
    .o_wr_addr(wa0), .o_wr_data(wd0), .o_busy(busy0), .o_done(done0),
    .o_error(err0), .o_word_count(cnt0)
  );

  instruction_loader #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(2), .HALT_WORD(32'hFFFF_FFFF)) dut1 (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_start(start),
    .i_rx_data(data), .i_rx_valid(valid), .o_ready(rdy1), .o_wr_en(we1),
    .o_wr_addr(wa1), .o_wr_data(wd1), .o_busy(busy1), .o_done(done1),
    .o_error(err1), .o_word_count(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Loader model: a load collects bytes four at a time; each full word becomes one
  // pending memory write that completes on the next enabled cycle.
  bit          m_load[2], m_wp[2], m_done[2], m_err[2];
  int          m_nb[2], m_addr[2], m_cnt[2], m_wa[2];
  logic [31:0] m_word[2], m_wd[2];

  function automatic int depth_of(input int i);
    return (i == 0) ? 256 : 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_load[i] <= 0; m_wp[i] <= 0; m_done[i] <= 0; m_err[i] <= 0;
        m_nb[i] <= 0; m_addr[i] <= 0; m_cnt[i] <= 0; m_wa[i] <= 0;
        m_word[i] <= '0; m_wd[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (m_wp[i]) begin
          m_wp[i]  <= 0;
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_word[i] == 32'hFFFF_FFFF) begin
            m_load[i] <= 0; m_done[i] <= 1;
          end else if (m_addr[i] == depth_of(i) - 1) begin
            m_load[i] <= 0; m_err[i] <= 1;
          end else begin
            m_addr[i] <= m_addr[i] + 1;
          end
        end else if (m_load[i]) begin
          if (valid) begin
            m_word[i] <= (m_word[i] << 8) | 32'(data);
            if (m_nb[i] == 3) begin
              m_nb[i] <= 0;
              m_wp[i] <= 1;
              m_wa[i] <= m_addr[i];
              m_wd[i] <= (m_word[i] << 8) | 32'(data);
            end else begin
              m_nb[i] <= m_nb[i] + 1;
            end
          end
        end else if (start) begin
          m_load[i] <= 1; m_done[i] <= 0; m_err[i] <= 0;
          m_addr[i] <= 0; m_cnt[i] <= 0; m_nb[i] <= 0; m_word[i] <= '0;
        end
      end
    end
  end

  int          log_a0[$], log_a1[$];
  logic [31:0] log_d0[$], log_d1[$];

  task automatic cmp_inst(input int i, input logic rdy, input logic we, input logic [31:0] wa,
                          input logic [31:0] wd, input logic busy, input logic done,
                          input logic err, input logic [31:0] cnt);
    check($sformatf("i%0d.ready", i), rdy, m_load[i] & ~m_wp[i] & en);
    check($sformatf("i%0d.wr_en", i), we, m_wp[i] & en);
    check($sformatf("i%0d.wr_addr", i), wa, m_wa[i]);
    check($sformatf("i%0d.wr_data", i), wd, m_wd[i]);
    check($sformatf("i%0d.busy", i), busy, m_load[i]);
    check($sformatf("i%0d.done", i), done, m_done[i]);
    check($sformatf("i%0d.error", i), err, m_err[i]);
    check($sformatf("i%0d.word_count", i), cnt, m_cnt[i]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, rdy0, we0, 32'(wa0), wd0, busy0, done0, err0, 32'(cnt0));
    cmp_inst(1, rdy1, we1, 32'(wa1), wd1, busy1, done1, err1, 32'(cnt1));
    if (we0) begin log_a0.push_back(int'(wa0)); log_d0.push_back(wd0); end
    if (we1) begin log_a1.push_back(int'(wa1)); log_d1.push_back(wd1); end
  end

  // NOTE: stimulus is driven with blocking assignments 1 ns after the rising edge,
  // so every input is settled long before the next edge samples it.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    valid = 1'b1;
    data  = b;
    n     = 0;
    acc   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk); #1;
      n++;
    end
    valid = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  int gap_i = 0;

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int b = 0; b < 4; b++) begin
      send_byte(w[31-8*b -: 8], gaps ? (gap_i % 4) : 0);
      gap_i++;
    end
  endtask

  task automatic check_zero0(input string tag);
    check({tag, ".ready"}, rdy0, 0);
    check({tag, ".wr_en"}, we0, 0);
    check({tag, ".busy"}, busy0, 0);
    check({tag, ".done"}, done0, 0);
    check({tag, ".error"}, err0, 0);
    check({tag, ".wr_addr"}, wa0, 0);
    check({tag, ".wr_data"}, wd0, 0);
    check({tag, ".word_count"}, cnt0, 0);
  endtask

  initial begin
    int base0, base1;
    #1;
    check_zero0("reset");

    @(posedge clk); #1;
    rst_n = 1'b1;
    valid = 1'b1;
    data  = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    valid = 1'b0;
    check("idle_busy", busy0, 0);
    check("idle_count", cnt0, 0);

    // Basic load
    pulse_start();
    send_word(32'h2008_0005, 0);
    send_word(32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    check("basic_nwrites", log_d0.size(), 2);
    check("basic_addr0", log_a0[0], 0);
    check("basic_data0", log_d0[0], 32'h2008_0005);
    check("basic_addr1", log_a0[1], 1);
    check("basic_data1", log_d0[1], 32'hFFFF_FFFF);
    check("basic_done", done0, 1);
    check("basic_count", cnt0, 2);

    // Restart from DONE, then the same program with idle gaps
    pulse_start();
    check("restart_done", done0, 0);
    check("restart_count", cnt0, 0);
    send_word(32'h2008_0005, 1);
    send_word(32'hFFFF_FFFF, 1);
    @(posedge clk); #1;
    check("gap_nwrites", log_d0.size(), 4);
    check("gap_addr0", log_a0[2], 0);
    check("gap_data0", log_d0[2], 32'h2008_0005);
    check("gap_addr1", log_a0[3], 1);
    check("gap_data1", log_d0[3], 32'hFFFF_FFFF);
    check("gap_done", done0, 1);

    // Enable stall while in WRITE
    pulse_start();
    send_word(32'h1122_3344, 0);
    en    = 1'b0;
    base0 = log_d0.size();
    repeat (5) @(posedge clk);
    #1;
    check("stall_nowrite", log_d0.size(), base0);
    check("stall_addr", wa0, 0);
    check("stall_busy", busy0, 1);
    en = 1'b1;
    @(posedge clk); #1;
    check("stall_onewrite", log_d0.size(), base0 + 1);
    check("stall_wr_addr", log_a0[base0], 0);
    check("stall_wr_data", log_d0[base0], 32'h1122_3344);
    send_word(32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    check("stall_done", done0, 1);

    // Full memory on the 4-word instance
    pulse_start();
    base1 = log_d1.size();
    for (int k = 0; k < 4; k++) send_word(32'hA0B0_C000 + 32'(k), 0);
    @(posedge clk); #1;
    check("full_error", err1, 1);
    check("full_count", cnt1, 4);
    check("full_busy", busy1, 0);
    check("full_nwrites", log_d1.size() - base1, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("full_addr%0d", k), log_a1[base1 + k], k);
      check($sformatf("full_data%0d", k), log_d1[base1 + k], 32'hA0B0_C000 + 32'(k));
    end
    check("full_big_error", err0, 0);
    send_word(32'h0BAD_F00D, 0);
    @(posedge clk); #1;
    check("full_nomore", log_d1.size() - base1, 4);
    check("full_error_held", err1, 1);
    check("full_big_addr4", log_a0[log_a0.size() - 1], 4);

    // Asynchronous reset after two bytes of a word
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero0("midword");
    check("midword_small_error", err1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_start();
    send_word(32'h1234_5678, 0);
    @(posedge clk); #1;
    base0 = log_d0.size();
    check("postreset_addr", log_a0[base0 - 1], 0);
    check("postreset_data", log_d0[base0 - 1], 32'h1234_5678);
    check("postreset_count", cnt0, 1);
    check("postreset_busy", busy0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter NB_DATA, default 32: instruction word width in bits.
REQ-002 Parameter NB_BYTE, default 8: received byte width in bits.
REQ-003 Parameter NB_ADDR, default 8: instruction memory word-address width.
REQ-004 Parameter HALT_WORD, default 32'hFFFF_FFFF: end-of-program marker word.
REQ-005 i_clock  input  1  single clock; all state updates on its rising edge.
REQ-006 i_reset  input  1  asynchronous, active-low reset.
REQ-007 i_enable  input  1  global advance enable.
REQ-008 i_start  input  1  one-cycle pulse that begins a program load.
REQ-009 i_rx_data  input  NB_BYTE  received byte, from the serial receiver.
REQ-010 i_rx_valid  input  1  i_rx_data is valid this cycle.
REQ-011 o_ready  output  1  loader accepts a byte this cycle.
REQ-012 o_wr_en  output  1  instruction-memory write strobe.
REQ-013 o_wr_addr  output  NB_ADDR  instruction-memory word address.
REQ-014 o_wr_data  output  NB_DATA  instruction word to write.
REQ-015 o_busy  output  1  load in progress.
REQ-016 o_done  output  1  halt word written; program loaded.
REQ-017 o_error  output  1  memory filled without a halt word.
REQ-018 o_word_count  output  NB_ADDR+1  number of words written in the current load.

Function
REQ-019 The FSM SHALL have the states IDLE, RECEIVE, WRITE, DONE and ERROR.
REQ-020 IDLE: i_start SHALL move the FSM to RECEIVE and clear the byte counter, word register, address and o_word_count.
REQ-021 o_ready SHALL be 1 only in RECEIVE with i_enable=1; a byte is accepted only when o_ready=1 and i_rx_valid=1. A byte that is valid while o_ready=0 SHALL be dropped.
REQ-022 Each accepted byte SHALL shift in MSB-first: word <= {word[NB_DATA-NB_BYTE-1:0], i_rx_data}. The byte counter SHALL increment modulo NB_DATA/NB_BYTE.
REQ-023 Acceptance of the 4th byte SHALL move the FSM to WRITE on the next edge.
REQ-024 WRITE SHALL last exactly one enabled cycle.
  - o_wr_en=1, o_wr_addr=current address, o_wr_data=assembled word.
  - o_word_count increments at the end of the cycle.
REQ-025 Leaving WRITE, when word==HALT_WORD: the FSM SHALL go to DONE and the address SHALL not increment.
REQ-026 Leaving WRITE, when the word is not HALT_WORD and address==2^NB_ADDR-1: the FSM SHALL go to ERROR.
REQ-027 Leaving WRITE in all other cases: the address SHALL increment by 1 and the FSM SHALL return to RECEIVE.
REQ-028 Latency: o_wr_en SHALL assert exactly 1 cycle after the edge on which the 4th byte is accepted.
REQ-029 o_busy SHALL be 1 in RECEIVE and WRITE, and 0 otherwise.
REQ-030 o_done SHALL be 1 only in DONE; o_error SHALL be 1 only in ERROR. Both SHALL be held until i_start.
REQ-031 i_start in DONE or ERROR SHALL restart the load exactly as in REQ-020.
REQ-032 i_start in RECEIVE or WRITE SHALL be ignored.
REQ-033 i_enable=0 SHALL freeze all state, counters and outputs, except o_wr_en and o_ready, which SHALL be forced to 0. WRITE SHALL be retained until i_enable returns to 1.
REQ-034 o_wr_data and o_wr_addr SHALL be registered. They SHALL hold their last values when o_wr_en=0.

Reset
REQ-035 While i_reset=0, the block SHALL immediately (asynchronously) force:
  - state to IDLE;
  - o_wr_en, o_ready, o_busy, o_done and o_error to 0;
  - o_wr_addr, o_wr_data, o_word_count, the byte counter and the word register to 0.
REQ-036 Reset asserted mid-word or mid-WRITE SHALL abort the load; no partial word SHALL ever be written.
REQ-037 After reset release, the block SHALL wait in IDLE for i_start. Bytes received while in IDLE SHALL be ignored.

Verification
REQ-038 Basic load: start; bytes 20,08,00,05, FF,FF,FF,FF.
  - o_wr_en at addr 0 with 32'h2008_0005.
  - o_wr_en at addr 1 with 32'hFFFF_FFFF.
  - o_done=1, o_word_count=2.
REQ-039 Gaps: the same bytes with 0-3 idle cycles between them (i_rx_valid=0) -> identical writes and values.
REQ-040 Full memory: NB_ADDR=2; 4 non-halt words -> writes at addr 0..3, then o_error=1, o_word_count=4, and no further writes.
REQ-041 Enable stall: i_enable=0 for 5 cycles while in WRITE -> o_wr_en=0 during the stall, a single write after release, and the address unchanged during the stall.
REQ-042 Reset mid-word: i_reset=0 after 2 bytes -> all outputs 0 at once. A subsequent start plus 4 bytes -> write at addr 0 with only the new bytes.
REQ-043 Restart: i_start in DONE -> o_done=0, o_word_count=0, and the next word is written at addr 0.
